// File: rtl/rob_complete.sv
// rob_complete: in-order reorder buffer; dispatch alloc (i_alloc_*, o_alloc_tag, o_rob_full), 3 FU completions (i_cmp_*), registered retire (o_ret_*), o_count, i_flush clears
module rob_complete #(
  parameter int DEPTH = 16,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_alloc_valid,
  input  logic [4:0]       i_alloc_rd,
  input  logic             i_alloc_wen,
  output logic [TAG_W-1:0] o_alloc_tag,
  output logic             o_rob_full,
  input  logic             i_cmp_valid  [0:2],
  input  logic [TAG_W-1:0] i_cmp_tag    [0:2],
  input  logic [31:0]      i_cmp_result [0:2],
  output logic             o_ret_valid,
  output logic [TAG_W-1:0] o_ret_tag,
  output logic [4:0]       o_ret_rd,
  output logic             o_ret_wen,
  output logic [31:0]      o_ret_data,
  output logic [TAG_W:0]   o_count
);
  logic             busy     [DEPTH];
  logic             done     [DEPTH];
  logic [4:0]       rd       [DEPTH];
  logic             wen      [DEPTH];
  logic [31:0]      data     [DEPTH];
  logic             hit      [DEPTH];
  logic [31:0]      hit_data [DEPTH];
  logic [TAG_W-1:0] head, tail;
  logic [TAG_W:0]   count;
  logic             alloc, retire;
  assign o_rob_full  = count == (TAG_W+1)'(DEPTH);
  assign o_alloc_tag = tail;
  assign o_count     = count;
  assign alloc       = i_alloc_valid && !o_rob_full;
  assign retire      = busy[head] && done[head];
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = 1'b0;
      hit_data[i] = '0;
      for (int p = 2; p >= 0; p--)
        if (i_cmp_valid[p] && i_cmp_tag[p] == TAG_W'(i) && busy[i]) begin
          hit[i] = 1'b1;
          hit_data[i] = i_cmp_result[p];
        end
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      o_ret_valid <= 1'b0;
      o_ret_tag   <= '0;
      o_ret_rd    <= '0;
      o_ret_wen   <= 1'b0;
      o_ret_data  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        busy[i] <= 1'b0;
        done[i] <= 1'b0;
        rd[i]   <= '0;
        wen[i]  <= 1'b0;
        data[i] <= '0;
      end
    end else begin
      head        <= head + TAG_W'(retire);
      tail        <= tail + TAG_W'(alloc);
      count       <= count + (TAG_W+1)'(alloc) - (TAG_W+1)'(retire);
      o_ret_valid <= retire;
      o_ret_tag   <= retire ? head : '0;
      o_ret_rd    <= retire ? rd[head] : '0;
      o_ret_wen   <= retire && wen[head];
      o_ret_data  <= retire ? data[head] : '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (retire && head == TAG_W'(i)) begin
          busy[i] <= 1'b0;
          done[i] <= 1'b0;
        end else if (alloc && tail == TAG_W'(i)) begin
          busy[i] <= 1'b1;
          done[i] <= 1'b0;
          rd[i]   <= i_alloc_rd;
          wen[i]  <= i_alloc_wen;
          data[i] <= '0;
        end else if (hit[i]) begin
          done[i] <= 1'b1;
          data[i] <= hit_data[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_rob_complete.sv
// tb_rob_complete: directed self-checking bench for rob_complete
module tb_rob_complete;
  logic        i_clk = 1'b0;
  logic        i_rst, i_flush, i_alloc_valid, i_alloc_wen;
  logic [4:0]  i_alloc_rd;
  logic [3:0]  o_alloc_tag;
  logic        o_rob_full;
  logic        i_cmp_valid  [0:2];
  logic [3:0]  i_cmp_tag    [0:2];
  logic [31:0] i_cmp_result [0:2];
  logic        o_ret_valid, o_ret_wen;
  logic [3:0]  o_ret_tag;
  logic [4:0]  o_ret_rd;
  logic [31:0] o_ret_data;
  logic [4:0]  o_count;
  int total = 0;
  int bad = 0;
  rob_complete #(.DEPTH(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_alloc_valid(i_alloc_valid), .i_alloc_rd(i_alloc_rd), .i_alloc_wen(i_alloc_wen),
    .o_alloc_tag(o_alloc_tag), .o_rob_full(o_rob_full),
    .i_cmp_valid(i_cmp_valid), .i_cmp_tag(i_cmp_tag), .i_cmp_result(i_cmp_result),
    .o_ret_valid(o_ret_valid), .o_ret_tag(o_ret_tag), .o_ret_rd(o_ret_rd),
    .o_ret_wen(o_ret_wen), .o_ret_data(o_ret_data), .o_count(o_count)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    i_rst = 1'b0;
    i_flush = 1'b0;
    i_alloc_valid = 1'b0;
    i_alloc_rd = '0;
    i_alloc_wen = 1'b0;
    for (int p = 0; p < 3; p++) begin
      i_cmp_valid[p] = 1'b0;
      i_cmp_tag[p] = '0;
      i_cmp_result[p] = '0;
    end
  endtask
  task automatic step();
    @(posedge i_clk);
    #1;
    idle();
  endtask
  task automatic alloc(input logic [4:0] rd, input logic wen);
    i_alloc_valid = 1'b1;
    i_alloc_rd = rd;
    i_alloc_wen = wen;
  endtask
  task automatic cmp(input int p, input logic [3:0] tag, input logic [31:0] res);
    i_cmp_valid[p] = 1'b1;
    i_cmp_tag[p] = tag;
    i_cmp_result[p] = res;
  endtask
  task automatic do_reset();
    idle();
    i_rst = 1'b1;
    step();
  endtask
  task automatic chk_ret(input string tag, input logic [3:0] t, input logic [4:0] rd, input logic wen, input logic [31:0] d);
    chk({tag, "_valid"}, 32'(o_ret_valid), 32'd1);
    chk({tag, "_tag"}, 32'(o_ret_tag), 32'(t));
    chk({tag, "_rd"}, 32'(o_ret_rd), 32'(rd));
    chk({tag, "_wen"}, 32'(o_ret_wen), 32'(wen));
    chk({tag, "_data"}, o_ret_data, d);
  endtask
  initial begin
    do_reset();
    step();
    chk("rst_valid", 32'(o_ret_valid), 32'd0);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_tag", 32'(o_alloc_tag), 32'd0);
    chk("rst_full", 32'(o_rob_full), 32'd0);
    chk("rst_data", o_ret_data, 32'd0);
    alloc(5'd5, 1'b1);
    #1;
    chk("t1_alloc_tag", 32'(o_alloc_tag), 32'd0);
    step();
    chk("t1_count1", 32'(o_count), 32'd1);
    cmp(0, 4'd0, 32'h2A);
    step();
    chk("t1_no_early_ret", 32'(o_ret_valid), 32'd0);
    step();
    chk_ret("t1_ret", 4'd0, 5'd5, 1'b1, 32'h2A);
    chk("t1_count0", 32'(o_count), 32'd0);
    step();
    chk("t1_pulse_end", 32'(o_ret_valid), 32'd0);
    chk("t1_data_zero", o_ret_data, 32'd0);
    do_reset();
    alloc(5'd1, 1'b1); step();
    alloc(5'd2, 1'b0); step();
    alloc(5'd3, 1'b1); step();
    cmp(2, 4'd2, 32'h11); step();
    cmp(1, 4'd1, 32'h22); step();
    chk("t2_wait_head", 32'(o_ret_valid), 32'd0);
    cmp(0, 4'd0, 32'h33); step();
    chk("t2_wait_done", 32'(o_ret_valid), 32'd0);
    step();
    chk_ret("t2_ret0", 4'd0, 5'd1, 1'b1, 32'h33);
    step();
    chk_ret("t2_ret1", 4'd1, 5'd2, 1'b0, 32'h22);
    step();
    chk_ret("t2_ret2", 4'd2, 5'd3, 1'b1, 32'h11);
    step();
    chk("t2_idle", 32'(o_ret_valid), 32'd0);
    chk("t2_count", 32'(o_count), 32'd0);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      alloc(5'(i), 1'b1);
      step();
    end
    chk("t3_full", 32'(o_rob_full), 32'd1);
    chk("t3_wrap_tag", 32'(o_alloc_tag), 32'd0);
    chk("t3_count16", 32'(o_count), 32'd16);
    alloc(5'd31, 1'b1); step();
    chk("t3_drop_count", 32'(o_count), 32'd16);
    chk("t3_drop_tag", 32'(o_alloc_tag), 32'd0);
    alloc(5'd30, 1'b1);
    cmp(1, 4'd0, 32'h77);
    step();
    alloc(5'd29, 1'b1);
    step();
    chk_ret("t3_ret0", 4'd0, 5'd0, 1'b1, 32'h77);
    chk("t3_count15", 32'(o_count), 32'd15);
    chk("t3_free_tag", 32'(o_alloc_tag), 32'd0);
    alloc(5'd9, 1'b0); step();
    chk("t3_refull", 32'(o_count), 32'd16);
    chk("t3_refull_flag", 32'(o_rob_full), 32'd1);
    chk("t3_tail1", 32'(o_alloc_tag), 32'd1);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alloc(5'(10 + i), 1'b1);
      step();
    end
    cmp(0, 4'd3, 32'hAAAA_AAAA);
    cmp(2, 4'd3, 32'h5555_5555);
    cmp(1, 4'd0, 32'h10);
    step();
    cmp(0, 4'd1, 32'h11);
    cmp(1, 4'd2, 32'h12);
    step();
    chk_ret("t4_ret0", 4'd0, 5'd10, 1'b1, 32'h10);
    step();
    chk_ret("t4_ret1", 4'd1, 5'd11, 1'b1, 32'h11);
    step();
    chk_ret("t4_ret2", 4'd2, 5'd12, 1'b1, 32'h12);
    step();
    chk_ret("t4_ret3", 4'd3, 5'd13, 1'b1, 32'hAAAA_AAAA);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alloc(5'(i + 1), 1'b1);
      step();
    end
    cmp(0, 4'd0, 32'h1);
    cmp(1, 4'd1, 32'h2);
    step();
    i_flush = 1'b1;
    alloc(5'd7, 1'b1);
    step();
    chk("t5_count", 32'(o_count), 32'd0);
    chk("t5_no_ret", 32'(o_ret_valid), 32'd0);
    chk("t5_tag0", 32'(o_alloc_tag), 32'd0);
    chk("t5_full", 32'(o_rob_full), 32'd0);
    step();
    chk("t5_no_ret2", 32'(o_ret_valid), 32'd0);
    cmp(1, 4'd7, 32'h99);
    step();
    step();
    chk("t6_stray_ret", 32'(o_ret_valid), 32'd0);
    chk("t6_stray_count", 32'(o_count), 32'd0);
    for (int i = 0; i < 8; i++) begin
      alloc(5'(20 + i), 1'b1);
      step();
    end
    chk("t6_count8", 32'(o_count), 32'd8);
    cmp(0, 4'd0, 32'h100);
    cmp(1, 4'd1, 32'h101);
    cmp(2, 4'd2, 32'h102);
    step();
    for (int k = 0; k < 7; k++) begin
      if (k == 0) begin
        cmp(0, 4'd3, 32'h103);
        cmp(1, 4'd4, 32'h104);
        cmp(2, 4'd5, 32'h105);
      end
      if (k == 1) cmp(2, 4'd6, 32'h106);
      step();
      chk_ret($sformatf("t6_ret%0d", k), 4'(k), 5'(20 + k), 1'b1, 32'h100 + 32'(k));
    end
    step();
    chk("t6_tag7_waits", 32'(o_ret_valid), 32'd0);
    chk("t6_count1", 32'(o_count), 32'd1);
    cmp(0, 4'd7, 32'h77);
    step();
    chk("t6_tag7_pending", 32'(o_ret_valid), 32'd0);
    step();
    chk_ret("t6_ret7", 4'd7, 5'd27, 1'b1, 32'h77);
    chk("t6_count0", 32'(o_count), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rob_complete.md
# rob_complete

Reorder buffer and complete/retire stage directly downstream of the issue stage. It allocates one entry per cycle in program order from dispatch and absorbs up to three functional-unit results per cycle: FU0 and FU1 are the ALUs, FU2 is the load unit. It retires the oldest completed entry in order, one per cycle, to the architectural register file. A flush discards all in-flight entries.

## Interface
Parameters:
- DEPTH, 16: ROB entries; power of two, at least 4.
- TAG_W, $clog2(DEPTH): entry tag width.

Ports:
- i_clk, in, 1: clock; all state updates on the rising edge.
- i_rst, in, 1: reset; synchronous, active-high.
- i_flush, in, 1: synchronous clear of all entries.
- i_alloc_valid, in, 1: dispatch requests one entry.
- i_alloc_rd, in, 5: destination register of the allocated instruction.
- i_alloc_wen, in, 1: instruction writes rd.
- o_alloc_tag, out, TAG_W: tag the next allocation receives; equals the tail pointer; combinational.
- o_rob_full, out, 1: count == DEPTH; combinational.
- i_cmp_valid[0:2], in, 1 each: FU result valid; same role as the issue stage's ready bit.
- i_cmp_tag[0:2], in, TAG_W each: ROB tag of the result.
- i_cmp_result[0:2], in, 32 each: FU result word.
- o_ret_valid, out, 1: retire pulse; registered.
- o_ret_tag, out, TAG_W: tag of the retired entry.
- o_ret_rd, out, 5: destination register of the retired entry.
- o_ret_wen, out, 1: o_ret_valid AND the entry's wen.
- o_ret_data, out, 32: result of the retired entry.
- o_count, out, TAG_W+1: occupied entries.

## Operation
- Each entry holds: busy, done, rd[4:0], wen, data[31:0].
- Pointers:
  - head: oldest entry; TAG_W bits, wraps DEPTH-1 -> 0.
  - tail: next free entry; TAG_W bits, wraps DEPTH-1 -> 0.
  - count: TAG_W+1 bits, ranges 0..DEPTH.
- Allocate: when i_alloc_valid && !o_rob_full, entry[tail] gets busy=1, done=0, rd, wen, data=0, and tail increments.
  - i_alloc_valid while full is dropped. No entry changes and no error is flagged; dispatch must hold the request.
  - Full is evaluated before a same-cycle retire frees a slot. A full ROB therefore blocks allocation for that cycle even if retire occurs.
- Complete: for each port p with i_cmp_valid[p], if entry[i_cmp_tag[p]] is busy, set done=1 and data=i_cmp_result[p].
  - A completion to a non-busy entry is ignored.
  - Same tag on several ports in one cycle: the lowest port index wins.
  - A completion to an entry that is already done overwrites its data. This is legal but not expected.
- Retire: when entry[head] is busy and done at the clock edge:
  - Register o_ret_* from entry[head] with o_ret_valid=1.
  - Clear busy and done on the entry; head increments.
  - Otherwise o_ret_valid=0, and the other o_ret_* outputs are 0.
- count: +1 on allocate only; -1 on retire only; unchanged when both occur or neither occurs.
- Flush: on i_flush, head=tail=0, count=0, all busy/done=0, o_ret_valid=0.
  - Same-cycle allocate, complete and retire are suppressed.
  - i_rst has priority over i_flush.
- Reset values:
  - head=tail=count=0; all entries cleared.
  - o_ret_valid=0, o_ret_tag=0, o_ret_rd=0, o_ret_wen=0, o_ret_data=0.
  - o_alloc_tag=0, o_rob_full=0, o_count=0.

## Timing
- Allocation: the tag is visible combinationally in the cycle of the request. The entry exists from the next edge.
- A completion sampled at edge N sets done. The earliest retire of that entry is edge N+1, so o_ret_valid is high during cycle N+1..N+2.
- Minimum allocate-to-retire latency is 2 edges: allocate at N, complete at N+1, retire at N+2.
- Throughput:
  - 1 allocation per cycle.
  - 3 completions per cycle.
  - 1 retire per cycle; back-to-back retires when consecutive entries are done.
- A done entry behind a not-done head waits; there is no out-of-order retire.
- Reset or flush takes effect at the edge where it is sampled high. Outputs show cleared values in the following cycle.

## Test plan
- Reset, then allocate rd=5/wen=1 (tag 0); complete port0 tag0 result 0x0000_002A. Required: o_ret_valid one cycle later with tag 0, rd 5, o_ret_wen=1, data 0x2A; o_count returns to 0.
- Allocate tags 0,1,2; complete tag2 (port2, 0x11), then tag1 (port1, 0x22), then tag0 (port0, 0x33). Required: retires in order 0,1,2 on three consecutive cycles after tag0 completes, with data 0x33, 0x22, 0x11.
- Allocate 16 entries: o_rob_full=1 and o_alloc_tag=0 (wrapped). A 17th allocate is ignored. Complete and retire tag0; the next allocate receives tag 0 and o_count returns to 16.
- In the same cycle, port0 and port2 complete tag3 with 0xAAAA_AAAA and 0x5555_5555. Required: tag3 retires 0xAAAA_AAAA.
- Allocate 4 entries and complete 2, then assert i_flush. Required: o_count=0, no retire in the next cycle, and the next allocation receives tag 0.
- Completion to a non-busy tag 7 when empty. Required: no state change and no retire; a later allocate of tag 7 retires only after its own completion.
